apb4_cfg_arbiter: RTL and testbench

- APB4 master that shares one APB4 register-block slave port (12-bit address, 32-bit data) between NREQ internal requesters, e.g. boot sequencer, debug bridge and firmware mailbox.
- Per requester: valid/ready request channel; response returned as a one-cycle pulse.
- Arbitration: round-robin.
- APB4 sequencing: SETUP then ACCESS, wait-state support, PSLVERR propagation.
- Watchdog aborts transfers whose PREADY never arrives.

---
 rtl/apb4_cfg_arbiter_if.sv | 41 ++++
 rtl/apb4_cfg_arbiter.sv | 137 +++++++++++++
 tb/tb_apb4_cfg_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_cfg_arbiter_if.sv
// Bundle of the requester channels and the APB4 master port of apb4_cfg_arbiter.
// Request channel: a transfer is accepted on a rising clk edge where req_valid[i] && req_ready[i];
// req_ready is combinational and at most one-hot. Responses are one-cycle rsp_valid pulses.
interface apb4_cfg_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 12,
  parameter int DW   = 32
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*DW-1:0]     req_wdata;
  logic [NREQ*DW/8-1:0]   req_strb;
  logic [NREQ-1:0]        rsp_valid;
  logic [DW-1:0]          rsp_rdata;
  logic                   rsp_err;
  logic                   rsp_timeout;
  logic [AW-1:0]          paddr;
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [DW-1:0]          pwdata;
  logic [DW/8-1:0]        pstrb;
  logic [2:0]             pprot;
  logic [DW-1:0]          prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, psel, penable, pwrite, pwdata, pstrb, pprot
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, psel, penable, pwrite, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/apb4_cfg_arbiter.sv
// Round-robin arbiter sharing one APB4 slave port between NREQ requesters,
// with SETUP/ACCESS sequencing, wait states, PSLVERR forwarding and a PREADY watchdog.
module apb4_cfg_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_b,
  apb4_cfg_arbiter_if.master  bus,
  output logic [1:0]          dbg_state
);
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW  = DW / 8;
  localparam int WDW = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, owner, gnt_idx, cand;
  logic            gnt_found, accept, done_ok, done_to;
  int              idx;
  logic [WDW-1:0]  wd;
  logic            psel_q, penable_q, pwrite_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q, rsp_rdata_q;
  logic [SW-1:0]   pstrb_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic            rsp_err_q, rsp_timeout_q;

  // Search starts at ptr and wraps, so the last owner is visited last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PW'(idx);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign accept  = (state == IDLE) && gnt_found;
  assign done_ok = (state == ACCESS) && bus.pready;
  assign done_to = (state == ACCESS) && !bus.pready && (wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done_ok || done_to) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr           <= '0;
      owner         <= '0;
      wd            <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= bus.req_write[gnt_idx];
            paddr_q   <= bus.req_addr[int'(gnt_idx)*AW +: AW];
            pwdata_q  <= bus.req_wdata[int'(gnt_idx)*DW +: DW];
            pstrb_q   <= bus.req_write[gnt_idx] ? bus.req_strb[int'(gnt_idx)*SW +: SW] : '0;
            owner     <= gnt_idx;
            ptr       <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            wd        <= '0;
          end
        end
        SETUP: penable_q <= 1'b1;
        ACCESS: begin
          if (done_ok) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= NREQ'(1) << owner;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q     <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
          end else if (done_to) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= NREQ'(1) << owner;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = 3'b010;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_apb4_cfg_arbiter.sv
// Randomized bench for apb4_cfg_arbiter: reference model predicts grants, APB fields,
// response timing and data; a monitor pops expected responses from exp_q.
module tb_apb4_cfg_arbiter;
  localparam int NREQ    = 3;
  localparam int AW      = 12;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 4;
  localparam int EW      = 32 + NREQ + DW + 2;
  localparam int FW      = AW + 1 + DW + SW;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  apb4_cfg_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  logic [1:0] dbg_state;

  apb4_cfg_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  int unsigned cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected response: {cycle, one-hot owner, rdata, err, timeout}
  logic [EW-1:0] exp_q[$];
  logic [FW-1:0] apb_q[$];
  int            beh_waits_q[$];
  logic [1:0]    beh_mode_q[$];   // 0 ok, 1 slave error, 2 never ready

  logic [DW-1:0]   ref_mem [1024];
  logic [DW-1:0]   slv_mem [1024];
  logic [NREQ-1:0] vld, acc;
  logic            r_write [NREQ];
  logic [AW-1:0]   r_addr  [NREQ];
  logic [DW-1:0]   r_wdata [NREQ];
  logic [SW-1:0]   r_strb  [NREQ];
  int              ptr_m = 0;
  int unsigned     busy_until = 0;
  bit              force_stuck = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic new_req(input int i);
    vld[i]     = 1'b1;
    r_write[i] = 1'($urandom_range(0, 1));
    r_addr[i]  = ($urandom_range(0, 9) == 0) ? 12'hFFC : 12'($urandom_range(0, 7) * 4);
    r_wdata[i] = $urandom;
    r_strb[i]  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
  endtask

  task automatic accept_model(input int g);
    logic [1:0]      mode;
    int              waits;
    int unsigned     rc;
    logic [DW-1:0]   rd;
    logic [NREQ-1:0] oh;
    acc[g] = 1'b1;
    ptr_m  = (g + 1) % NREQ;
    waits  = $urandom_range(0, TIMEOUT - 1);
    if (force_stuck || $urandom_range(0, 11) == 0) mode = 2'd2;
    else if ($urandom_range(0, 9) == 0)            mode = 2'd1;
    else                                           mode = 2'd0;
    force_stuck = 1'b0;
    beh_waits_q.push_back(waits);
    beh_mode_q.push_back(mode);
    apb_q.push_back({r_addr[g], r_write[g], r_wdata[g], r_write[g] ? r_strb[g] : 4'h0});
    rc = (mode == 2'd2) ? cyc + 2 + TIMEOUT : cyc + 3 + waits;
    if (mode == 2'd2 || r_write[g]) rd = '0;
    else if (mode == 2'd1)          rd = 32'hDEAD_BEEF;
    else                            rd = ref_mem[r_addr[g][11:2]];
    if (r_write[g] && mode == 2'd0)
      for (int b = 0; b < SW; b++)
        if (r_strb[g][b]) ref_mem[r_addr[g][11:2]][8*b +: 8] = r_wdata[g][8*b +: 8];
    oh = NREQ'(1) << g;
    exp_q.push_back({rc, oh, rd, (mode != 2'd0), (mode == 2'd2)});
    busy_until = rc;
  endtask

  task automatic model_eval();
    int g;
    logic [NREQ-1:0] er;
    g   = -1;
    acc = '0;
    if (rst_b && cyc >= busy_until)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && vld[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
    er = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    if (g >= 0) accept_model(g);
  endtask

  task automatic step(input int p_new, input bit allow_withdraw);
    bit wd;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      wd = 1'b0;
      if (acc[i]) vld[i] = 1'b0;
      else if (vld[i] && allow_withdraw && $urandom_range(0, 19) == 0) begin
        vld[i] = 1'b0;
        wd = 1'b1;
      end
      if (!vld[i] && !wd && p_new > 0 && $urandom_range(0, 99) < p_new) new_req(i);
      bus.req_valid[i]             = vld[i];
      bus.req_write[i]             = r_write[i];
      bus.req_addr[i*AW +: AW]     = r_addr[i];
      bus.req_wdata[i*DW +: DW]    = r_wdata[i];
      bus.req_strb[i*SW +: SW]     = r_strb[i];
    end
    @(negedge clk);
    model_eval();
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (vld != '0 || exp_q.size() != 0 || cyc < busy_until); k++)
      step(0, 1'b0);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every response pulse must match the head of exp_q.
  initial begin
    logic [EW-1:0]   e;
    logic [31:0]     e_cyc;
    logic [NREQ-1:0] e_oh;
    logic [DW-1:0]   e_rd;
    logic            e_err, e_to;
    forever begin
      @(negedge clk);
      if (rst_b && bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          {e_cyc, e_oh, e_rd, e_err, e_to} = e;
          chk("rsp_cycle",   64'(cyc), 64'(e_cyc));
          chk("rsp_owner",   64'(bus.rsp_valid), 64'(e_oh));
          chk("rsp_rdata",   64'(bus.rsp_rdata), 64'(e_rd));
          chk("rsp_err",     64'(bus.rsp_err), 64'(e_err));
          chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e_to));
        end
      end
    end
  end

  // APB slave: behaviour per transfer comes from the model's queues.
  initial begin
    logic [FW-1:0] snap;
    int            cur_waits, wcnt;
    logic [1:0]    cur_mode;
    bit            in_xfer;
    in_xfer = 1'b0; cur_waits = 0; cur_mode = 2'd0; wcnt = 0; snap = '0;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_b) in_xfer = 1'b0;
      if (rst_b && bus.psel && !bus.penable) begin
        chk("setup_expected", 64'(beh_mode_q.size() != 0), 64'd1);
        if (beh_mode_q.size() != 0) begin
          cur_mode  = beh_mode_q.pop_front();
          cur_waits = beh_waits_q.pop_front();
          snap      = apb_q.pop_front();
          chk("setup_fields", 64'({bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb}), 64'(snap));
          chk("pprot", 64'(bus.pprot), 64'(3'b010));
          wcnt    = 0;
          in_xfer = 1'b1;
        end
        bus.pready = 1'($urandom); bus.pslverr = 1'($urandom); bus.prdata = $urandom;
      end else if (rst_b && bus.psel && bus.penable && in_xfer) begin
        chk("access_hold", 64'({bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb}), 64'(snap));
        if (cur_mode != 2'd2 && wcnt == cur_waits) begin
          bus.pready  = 1'b1;
          bus.pslverr = (cur_mode == 2'd1);
          if (cur_mode == 2'd1)  bus.prdata = 32'hDEAD_BEEF;
          else if (bus.pwrite)   bus.prdata = $urandom;
          else                   bus.prdata = slv_mem[bus.paddr[11:2]];
          if (bus.pwrite && cur_mode == 2'd0)
            for (int b = 0; b < SW; b++)
              if (bus.pstrb[b]) slv_mem[bus.paddr[11:2]][8*b +: 8] = bus.pwdata[8*b +: 8];
          in_xfer = 1'b0;
        end else begin
          bus.pready = 1'b0; bus.pslverr = 1'($urandom); bus.prdata = $urandom;
          wcnt++;
        end
      end else begin
        bus.pready = 1'($urandom); bus.pslverr = 1'($urandom); bus.prdata = $urandom;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL sim_time_limit: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    for (int a = 0; a < 1024; a++) begin
      ref_mem[a] = '0;
      slv_mem[a] = '0;
    end
    vld = '0; acc = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_write[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_strb[i] = '0;
    end
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_strb = '0;

    #1;
    chk("rst_psel",        64'(bus.psel), 64'd0);
    chk("rst_penable",     64'(bus.penable), 64'd0);
    chk("rst_pwrite",      64'(bus.pwrite), 64'd0);
    chk("rst_paddr",       64'(bus.paddr), 64'd0);
    chk("rst_pwdata",      64'(bus.pwdata), 64'd0);
    chk("rst_pstrb",       64'(bus.pstrb), 64'd0);
    chk("rst_rsp_valid",   64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata",   64'(bus.rsp_rdata), 64'd0);
    chk("rst_rsp_err",     64'(bus.rsp_err), 64'd0);
    chk("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    chk("rst_state",       64'(dbg_state), 64'd0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    repeat (300)  step(100, 1'b0);
    repeat (1500) step(35, 1'b1);
    drain();

    // Asynchronous reset in the middle of an ACCESS phase.
    force_stuck = 1'b1;
    new_req(1);
    r_write[1] = 1'b0;
    r_addr[1]  = 12'h010;
    for (int k = 0; k < 10 && !acc[1]; k++) step(0, 1'b0);
    chk("rst_test_grant", 64'(acc[1]), 64'd1);
    step(0, 1'b0);
    step(0, 1'b0);
    chk("pre_rst_penable", 64'(bus.penable), 64'd1);
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_psel",    64'(bus.psel), 64'd0);
    chk("async_rst_penable", 64'(bus.penable), 64'd0);
    chk("async_rst_state",   64'(dbg_state), 64'd0);
    exp_q.delete(); apb_q.delete(); beh_waits_q.delete(); beh_mode_q.delete();
    ptr_m = 0; busy_until = 0; acc = '0; vld = '0;
    step(0, 1'b0);
    step(0, 1'b0);
    #2 rst_b = 1'b1;
    new_req(0);
    new_req(1);
    repeat (20)  step(0, 1'b0);
    repeat (400) step(60, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
